// File: rtl/bbox_collector.sv
// Bounding-box collector: tracks min/max of an accepted (x,y) stream and
// reports origin, extents, point count and whether the box was fully covered.
module bbox_collector #(
    parameter int WIDTH = 32
) (
    input  logic             _clock,
    input  logic             _reset_n,
    input  logic             _start,
    input  logic             _valid,
    input  logic [WIDTH-1:0] _in0,
    input  logic [WIDTH-1:0] _in1,
    input  logic             _last,
    output logic             _ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_width,
    output logic [WIDTH-1:0] out_height,
    output logic [WIDTH-1:0] _count,
    output logic             _filled,
    output logic             _empty,
    output logic             _done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] REPORT  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] min_x, min_y, max_x, max_y;
    logic [WIDTH-1:0] nmin_x, nmin_y, nmax_x, nmax_y, ncount;
    logic [WIDTH-1:0] wid, hgt, prod;
    logic             accept;

    assign _ready = (state == COLLECT);
    assign accept = _valid && _ready && !_start;

    // Next-state accumulators so a coordinate coincident with _last is folded in
    always_comb begin
        nmin_x = min_x;
        nmin_y = min_y;
        nmax_x = max_x;
        nmax_y = max_y;
        ncount = _count;
        if (accept) begin
            if (_in0 < min_x) nmin_x = _in0;
            if (_in0 > max_x) nmax_x = _in0;
            if (_in1 < min_y) nmin_y = _in1;
            if (_in1 > max_y) nmax_y = _in1;
            if (_count != {WIDTH{1'b1}}) ncount = _count + 1'b1;
        end
    end

    assign wid  = nmax_x - nmin_x + 1'b1;
    assign hgt  = nmax_y - nmin_y + 1'b1;
    assign prod = wid * hgt;

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state      <= IDLE;
            min_x      <= '1;
            min_y      <= '1;
            max_x      <= '0;
            max_y      <= '0;
            _count     <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_width  <= '0;
            out_height <= '0;
            _filled    <= 1'b0;
            _empty     <= 1'b0;
            _done      <= 1'b0;
        end else begin
            _done <= 1'b0;
            if (_start) begin
                // Restart from any state; a concurrent _valid/_last is dropped
                state      <= COLLECT;
                min_x      <= '1;
                min_y      <= '1;
                max_x      <= '0;
                max_y      <= '0;
                _count     <= '0;
                out_x      <= '0;
                out_y      <= '0;
                out_width  <= '0;
                out_height <= '0;
                _filled    <= 1'b0;
                _empty     <= 1'b0;
            end else if (state == COLLECT) begin
                min_x  <= nmin_x;
                min_y  <= nmin_y;
                max_x  <= nmax_x;
                max_y  <= nmax_y;
                _count <= ncount;
                if (_last) begin
                    state <= REPORT;
                    _done <= 1'b1;
                    if (ncount == '0) begin
                        out_x      <= '0;
                        out_y      <= '0;
                        out_width  <= '0;
                        out_height <= '0;
                        _filled    <= 1'b0;
                        _empty     <= 1'b1;
                    end else begin
                        out_x      <= nmin_x;
                        out_y      <= nmin_y;
                        out_width  <= wid;
                        out_height <= hgt;
                        _filled    <= (prod == ncount);
                        _empty     <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bbox_collector.sv
// Directed bench for bbox_collector: raster, outline, empty, gaps, restart, async reset.
module tb_bbox_collector;

    localparam int W = 32;

    logic         _clock = 1'b0;
    logic         _reset_n = 1'b0;
    logic         _start = 1'b0;
    logic         _valid = 1'b0;
    logic [W-1:0] _in0 = '0;
    logic [W-1:0] _in1 = '0;
    logic         _last = 1'b0;
    logic         _ready;
    logic [W-1:0] out_x, out_y, out_width, out_height, _count;
    logic         _filled, _empty, _done;

    int tests = 0;
    int fails = 0;

    bbox_collector #(.WIDTH(W)) dut (
        ._clock(_clock), ._reset_n(_reset_n), ._start(_start), ._valid(_valid),
        ._in0(_in0), ._in1(_in1), ._last(_last), ._ready(_ready),
        .out_x(out_x), .out_y(out_y), .out_width(out_width), .out_height(out_height),
        ._count(_count), ._filled(_filled), ._empty(_empty), ._done(_done)
    );

    always #5 _clock = ~_clock;

    task automatic tick();
        @(posedge _clock);
        #1;
    endtask

    task automatic do_start();
        _start = 1'b1; tick(); _start = 1'b0;
    endtask

    task automatic point(input int x, input int y, input logic lst);
        _valid = 1'b1; _in0 = W'(x); _in1 = W'(y); _last = lst;
        tick();
        _valid = 1'b0; _last = 1'b0;
    endtask

    task automatic end_stream();
        _last = 1'b1; tick(); _last = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        tests++;
        if ({_ready, _done, _filled, _empty} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {_ready, _done, _filled, _empty});
        end
        tests++;
        if ({out_x, out_y, out_width, out_height, _count} !== '0) begin
            fails++; $display("FAIL reset_values got %0d %0d %0d %0d %0d want 0", out_x, out_y, out_width, out_height, _count);
        end
        _reset_n = 1'b1;
        _valid = 1'b1; _last = 1'b1;
        tick();
        _valid = 1'b0; _last = 1'b0;
        tests++;
        if ({_ready, _done, _count} !== {2'b00, 32'd0}) begin
            fails++; $display("FAIL idle_ignore got ready=%b done=%b count=%0d want 0 0 0", _ready, _done, _count);
        end
    endtask

    task automatic test_full_raster();
        do_start();
        tests++;
        if (_ready !== 1'b1) begin fails++; $display("FAIL raster_ready got %b want 1", _ready); end
        for (int y = 2; y < 5; y++)
            for (int x = 1; x < 5; x++) point(x, y, 1'b0);
        tests++;
        if ({_filled, _empty} !== 2'b00) begin
            fails++; $display("FAIL collect_flags got %b want 00", {_filled, _empty});
        end
        end_stream();
        tests++;
        if ({out_x, out_y, out_width, out_height, _count} !== {32'd1, 32'd2, 32'd4, 32'd3, 32'd12}) begin
            fails++; $display("FAIL raster_result got x=%0d y=%0d w=%0d h=%0d n=%0d want 1 2 4 3 12", out_x, out_y, out_width, out_height, _count);
        end
        tests++;
        if ({_done, _filled, _empty, _ready} !== 4'b1100) begin
            fails++; $display("FAIL raster_flags got %b want 1100", {_done, _filled, _empty, _ready});
        end
        _valid = 1'b1; _in0 = 32'd100; _in1 = 32'd100; _last = 1'b1;
        tick();
        _valid = 1'b0; _last = 1'b0;
        tests++;
        if ({_done, _count, out_width, _filled} !== {1'b0, 32'd12, 32'd4, 1'b1}) begin
            fails++; $display("FAIL report_hold got done=%b n=%0d w=%0d f=%b want 0 12 4 1", _done, _count, out_width, _filled);
        end
    endtask

    task automatic test_outline();
        do_start();
        for (int x = 1; x < 5; x++) point(x, 2, 1'b0);
        point(1, 3, 1'b0);
        point(4, 3, 1'b0);
        for (int x = 1; x < 5; x++) point(x, 4, 1'b0);
        end_stream();
        tests++;
        if ({out_x, out_y, out_width, out_height, _count} !== {32'd1, 32'd2, 32'd4, 32'd3, 32'd10}) begin
            fails++; $display("FAIL outline_result got x=%0d y=%0d w=%0d h=%0d n=%0d want 1 2 4 3 10", out_x, out_y, out_width, out_height, _count);
        end
        tests++;
        if ({_done, _filled, _empty} !== 3'b100) begin
            fails++; $display("FAIL outline_flags got %b want 100", {_done, _filled, _empty});
        end
    endtask

    task automatic test_empty();
        do_start();
        end_stream();
        tests++;
        if ({_done, _filled, _empty} !== 3'b101) begin
            fails++; $display("FAIL empty_flags got %b want 101", {_done, _filled, _empty});
        end
        tests++;
        if ({out_x, out_y, out_width, out_height, _count} !== '0) begin
            fails++; $display("FAIL empty_values got %0d %0d %0d %0d %0d want 0", out_x, out_y, out_width, out_height, _count);
        end
        tick();
        tests++;
        if ({_done, _empty} !== 2'b01) begin
            fails++; $display("FAIL empty_done_pulse got %b want 01", {_done, _empty});
        end
    endtask

    task automatic test_gaps_last();
        do_start();
        tick();
        point(5, 5, 1'b0);
        tick(); tick();
        point(7, 6, 1'b1);
        tests++;
        if ({out_x, out_y, out_width, out_height, _count} !== {32'd5, 32'd5, 32'd3, 32'd2, 32'd2}) begin
            fails++; $display("FAIL gaps_result got x=%0d y=%0d w=%0d h=%0d n=%0d want 5 5 3 2 2", out_x, out_y, out_width, out_height, _count);
        end
        tests++;
        if ({_done, _filled, _empty} !== 3'b100) begin
            fails++; $display("FAIL gaps_flags got %b want 100", {_done, _filled, _empty});
        end
    endtask

    task automatic test_restart();
        do_start();
        point(1, 1, 1'b0);
        point(20, 30, 1'b0);
        point(3, 4, 1'b0);
        // restart with a coincident point and _last: both must be dropped
        _start = 1'b1; _valid = 1'b1; _last = 1'b1; _in0 = 32'd50; _in1 = 32'd50;
        tick();
        _start = 1'b0; _valid = 1'b0; _last = 1'b0;
        tests++;
        if ({_ready, _done, _count} !== {2'b10, 32'd0}) begin
            fails++; $display("FAIL restart_state got ready=%b done=%b n=%0d want 1 0 0", _ready, _done, _count);
        end
        point(9, 9, 1'b1);
        tests++;
        if ({out_x, out_y, out_width, out_height, _count} !== {32'd9, 32'd9, 32'd1, 32'd1, 32'd1}) begin
            fails++; $display("FAIL restart_result got x=%0d y=%0d w=%0d h=%0d n=%0d want 9 9 1 1 1", out_x, out_y, out_width, out_height, _count);
        end
        tests++;
        if ({_done, _filled, _empty} !== 3'b110) begin
            fails++; $display("FAIL restart_flags got %b want 110", {_done, _filled, _empty});
        end
    endtask

    task automatic test_async_reset();
        do_start();
        point(3, 3, 1'b0);
        point(6, 8, 1'b0);
        #2;
        _reset_n = 1'b0;
        #1;
        tests++;
        if ({_ready, _count, _done, _filled, _empty} !== '0) begin
            fails++; $display("FAIL async_reset got ready=%b n=%0d want 0 0", _ready, _count);
        end
        tick();
        _reset_n = 1'b1;
        _valid = 1'b1; _in0 = 32'd4; _in1 = 32'd4; _last = 1'b1;
        tick(); tick();
        _valid = 1'b0; _last = 1'b0;
        tests++;
        if ({_ready, _done, _count, out_x} !== '0) begin
            fails++; $display("FAIL post_reset_idle got ready=%b done=%b n=%0d x=%0d want 0", _ready, _done, _count, out_x);
        end
        do_start();
        point(2, 7, 1'b1);
        tests++;
        if ({out_x, out_y, _count, _done} !== {32'd2, 32'd7, 32'd1, 1'b1}) begin
            fails++; $display("FAIL post_reset_run got x=%0d y=%0d n=%0d done=%b want 2 7 1 1", out_x, out_y, _count, _done);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_full_raster();
        test_outline();
        test_empty();
        test_gaps_last();
        test_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bbox_collector.md
BBOX_COLLECTOR -- requirements
Module: bbox_collector

Interface
REQ-001 SHALL declare parameter WIDTH, default 32, the bit width of coordinates, extents and count.
REQ-002 SHALL have port _clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port _reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port _start, input, 1 bit: one-cycle pulse that clears the accumulators and arms collection.
REQ-005 SHALL have port _valid, input, 1 bit: the coordinate on _in0/_in1 is present this cycle.
REQ-006 SHALL have port _in0, input, WIDTH bits: unsigned x coordinate from the rectangle generator's _out0.
REQ-007 SHALL have port _in1, input, WIDTH bits: unsigned y coordinate from the generator's _out1.
REQ-008 SHALL have port _last, input, 1 bit: end of stream, driven from the generator's _done.
REQ-009 SHALL have port _ready, output, 1 bit: the block accepts a coordinate this cycle.
REQ-010 SHALL have port out_x, output, WIDTH bits: recovered s_x (minimum x).
REQ-011 SHALL have port out_y, output, WIDTH bits: recovered s_y (minimum y).
REQ-012 SHALL have port out_width, output, WIDTH bits: recovered width.
REQ-013 SHALL have port out_height, output, WIDTH bits: recovered height.
REQ-014 SHALL have port _count, output, WIDTH bits: number of coordinates accepted.
REQ-015 SHALL have port _filled, output, 1 bit: _count equals out_width*out_height.
REQ-016 SHALL have port _empty, output, 1 bit: the stream ended with zero coordinates.
REQ-017 SHALL have port _done, output, 1 bit: one-cycle pulse when the results become valid.

Function
REQ-018 SHALL implement a state machine with states IDLE, COLLECT and REPORT.
REQ-019 SHALL move IDLE->COLLECT or REPORT->COLLECT on _start=1, clearing min_x/min_y to all-ones, max_x/max_y to 0 and the count to 0.
REQ-020 SHALL drive _ready=1 only in COLLECT; a coordinate is accepted only when _valid&&_ready.
REQ-021 SHALL, on each accepted coordinate, update min_x, max_x, min_y and max_y, and increment the count, in the same edge.
REQ-022 SHALL saturate the count at 2^WIDTH-1 rather than wrap.
REQ-023 SHALL, when _last=1 in COLLECT, go to REPORT on the next edge; if _valid=1 in that same cycle, that coordinate is accepted and included first.
REQ-024 SHALL, on entering REPORT, compute: out_x=min_x; out_y=min_y; out_width=max_x-min_x+1; out_height=max_y-min_y+1; each truncated to WIDTH bits, unsigned.
REQ-025 SHALL compute _filled from the WIDTH-bit truncated product out_width*out_height compared with _count; a registered or multi-cycle multiply is allowed only if _done still meets REQ-026.
REQ-026 SHALL assert _done for exactly one cycle, the cycle after the edge on which _last was sampled; all result outputs are valid in that cycle.
REQ-027 SHALL hold all result outputs stable in REPORT until the next _start.
REQ-028 SHALL, for an empty stream (_last with count 0), report out_x, out_y, out_width, out_height = 0, _filled=0 and _empty=1.
REQ-029 SHALL, on _start during COLLECT, discard the partial accumulation, clear as in REQ-019 and stay in COLLECT; a _valid in that cycle is not accepted.
REQ-030 SHALL, when _start and _last are both high in COLLECT, give _start priority.
REQ-031 SHALL ignore _valid and _last in IDLE and REPORT.
REQ-032 SHALL leave _empty=0 and _filled=0 while in COLLECT.

Reset
REQ-033 SHALL, on _reset_n=0, immediately and regardless of clock, enter IDLE and force _ready=0, _done=0, _filled=0, _empty=0, and all WIDTH-bit outputs and _count to 0.
REQ-034 SHALL, on reset mid-COLLECT, lose the partial results and require a new _start after _reset_n rises.
REQ-035 SHALL release reset synchronously to _clock and take no action on the first edge after release unless _start=1.

Verification
REQ-036 SHALL cover: full raster from draw_rectangle with s_x=1, s_y=2, height=3, width=4 (12 points), then _last -> out_x=1, out_y=2, out_width=4, out_height=3, _count=12, _filled=1, _done one cycle.
REQ-037 SHALL cover: outline only of the same rectangle (10 points) -> same extents, _count=10, _filled=0.
REQ-038 SHALL cover: _start then _last with no _valid -> _empty=1, all extents 0, _done pulse.
REQ-039 SHALL cover: _valid gaps and the final point coincident with _last, points (5,5),(7,6) -> out_width=3, out_height=2, _count=2.
REQ-040 SHALL cover: _start after 3 points in COLLECT, then single point (9,9) and _last -> out_x=9, out_y=9, out_width=out_height=1, _count=1, _filled=1.
REQ-041 SHALL cover: _reset_n=0 mid-COLLECT, asynchronously between clock edges -> outputs 0 at once; _ready stays 0 until the next _start.
